timer_ctrl: RTL and testbench
=============================

# timer_ctrl

Parametrised stopwatch/countdown controller for the timer datapath. It combines a run/stop/increment state machine with a prescaled tick counter, up/down counting, a countdown alarm, manual increment with auto-repeat, preset load and lap freeze. It sits between the debounced button inputs and the display driver, and replaces the bare state-only controller with a block that owns the count value itself.

## Interface
- CNT_W, 16: count and display width in bits, minimum 2.
- PRESCALE, 50000: clk cycles per tick, minimum 2.
- HOLD_TICKS, 8: ticks `inc` must stay held in INC before auto-repeat starts, minimum 1.
- clk  in  1  system clock; all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  synchronous request to run.
- stop  in  1  synchronous request to stop; highest priority.
- inc  in  1  manual increment, level, held for auto-repeat.
- lap  in  1  single-cycle pulse; toggles display freeze while running.
- dir  in  1  run direction: 0 counts up, 1 counts down; sampled on every tick.
- load  in  1  single-cycle preset strobe.
- load_val  in  CNT_W  preset value.
- state  out  2  current state: STOP=2'b00, RUN=2'b01, INC=2'b10, DONE=2'b11.
- count  out  CNT_W  live count value.
- display  out  CNT_W  shows `count`, or the held lap value while frozen.
- alarm  out  1  one-cycle pulse when a countdown reaches 0.
- wrap  out  1  one-cycle pulse when `count` wraps, up or down.

## Operation
- Reset (`reset_n`=0, immediate): state=STOP, count=0, display=0, alarm=0, wrap=0, prescaler=0, freeze=0, hold counter=0.
- Prescaler:
  - Counts 0..PRESCALE-1 only in RUN and INC; tick=1 when it equals PRESCALE-1, then it returns to 0.
  - Forced to 0 in STOP and DONE, and on every state change.
- STOP, priority stop > load > start > inc:
  - load: count=load_val, freeze=0, stays STOP.
  - start: to RUN, unless dir=1 and count=0; that start is ignored.
  - inc: to INC and count+1 on the same edge, wrapping 2^CNT_W-1→0 with a wrap pulse.
- RUN:
  - stop: to STOP. A tick in that same cycle is discarded and count holds.
  - Tick with dir=0: count+1; 2^CNT_W-1→0 pulses wrap.
  - Tick with dir=1: count-1. When count goes 1→0: alarm=1, state to DONE. Entering RUN with count=0 and dir=1 cannot occur.
  - lap: freeze=0 captures display=count and sets freeze=1; freeze=1 clears freeze=0.
  - start, load, inc: ignored.
- INC:
  - inc=0 or stop=1: to STOP.
  - Otherwise the hold counter counts ticks. From the HOLD_TICKS-th tick on, every tick does count+1 with wrap rules, then the hold counter saturates.
  - Hold counter clears on entry to INC.
  - dir is ignored; INC always counts up.
- DONE:
  - Holds count=0.
  - stop: to STOP. load: count=load_val, to STOP.
  - start and inc: ignored.
- display = freeze ? lap_reg : count.
  - freeze persists through STOP; it clears on load or reset.
  - lap outside RUN is ignored.
- Illegal state encodings do not exist with 2 bits; all four are used.

## Timing
- All outputs are registered.
- state, count, alarm and wrap change on the same edge as the triggering input or tick.
- start sampled high at edge n: state=RUN after edge n. The first count change follows edge n+PRESCALE.
- inc in STOP at edge n: state=INC and count+1 after edge n. Auto-repeat begins on the HOLD_TICKS-th tick, i.e. HOLD_TICKS·PRESCALE cycles after entry, then every PRESCALE cycles.
- alarm and wrap are high for exactly one cycle.
- display follows count with zero extra latency when not frozen.
- reset_n deassertion is synchronised upstream; the first active edge after release behaves as in STOP.

## Test plan
All scenarios use CNT_W=4, PRESCALE=4, HOLD_TICKS=2.
- Reset mid-RUN with count=5 → all outputs return to 0 and state=STOP immediately, without waiting for clk.
- load_val=3, load; dir=1, start → count 3,2,1,0 at 4-cycle spacing. alarm pulses on the 1→0 edge with state=DONE. A later start is ignored; stop returns to STOP.
- dir=0, count=14, start → 15, then 0 with a wrap pulse. stop in the same cycle as a tick leaves count unchanged.
- inc held for 20 cycles from count=0 → count=1 at entry, 2 at cycle 8, 3 at cycle 12, 4 at cycle 16, 5 at cycle 20. Releasing inc → STOP.
- In RUN, lap at count=6 → display stays 6 while count advances to 9. A second lap makes display=count. lap in STOP is ignored.
- start and stop together in STOP → stays STOP. start and inc together → RUN with no increment. dir=1 with count=0 and start → stays STOP.

Source files
------------

// File: rtl/timer_ctrl.sv
// timer_ctrl: stopwatch/countdown controller with prescaled tick, up/down
// count, countdown alarm, manual increment with auto-repeat, preset and lap.
// Ports: clk, reset_n (async low); start/stop/inc/lap/dir/load, load_val in;
//        state, count, display, alarm, wrap out.
module timer_ctrl #(
    parameter int CNT_W      = 16,
    parameter int PRESCALE   = 50000,
    parameter int HOLD_TICKS = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             stop,
    input  logic             inc,
    input  logic             lap,
    input  logic             dir,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] count,
    output logic [CNT_W-1:0] display,
    output logic             alarm,
    output logic             wrap
);

    localparam int PS_W = $clog2(PRESCALE);
    localparam int HC_W = $clog2(HOLD_TICKS + 1);
    localparam logic [PS_W-1:0] PS_MAX  = PS_W'(PRESCALE - 1);
    localparam logic [HC_W-1:0] HC_LAST = HC_W'(HOLD_TICKS - 1);

    typedef enum logic [1:0] {
        S_STOP = 2'b00,
        S_RUN  = 2'b01,
        S_INC  = 2'b10,
        S_DONE = 2'b11
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] lap_q, lap_d;
    logic [PS_W-1:0]  presc_q, presc_d;
    logic [HC_W-1:0]  hold_q, hold_d;
    logic             freeze_q, freeze_d;
    logic             alarm_q, alarm_d;
    logic             wrap_q, wrap_d;

    logic             counting;
    logic             tick;
    logic             cnt_max;
    logic [CNT_W-1:0] cnt_up;

    always_comb begin
        counting = (state_q == S_RUN) || (state_q == S_INC);
        tick     = counting && (presc_q == PS_MAX);
        cnt_max  = (count_q == '1);
        cnt_up   = count_q + CNT_W'(1);

        state_d  = state_q;
        count_d  = count_q;
        lap_d    = lap_q;
        freeze_d = freeze_q;
        hold_d   = hold_q;
        alarm_d  = 1'b0;
        wrap_d   = 1'b0;

        unique case (state_q)
            S_STOP: begin
                if (stop) begin
                    state_d = S_STOP;
                end else if (load) begin
                    count_d  = load_val;
                    freeze_d = 1'b0;
                end else if (start && !(dir && count_q == '0)) begin
                    state_d = S_RUN;
                end else if (inc) begin
                    // First increment is immediate; repeat waits for ticks.
                    state_d = S_INC;
                    count_d = cnt_up;
                    wrap_d  = cnt_max;
                    hold_d  = '0;
                end
            end
            S_RUN: begin
                if (lap) begin
                    if (freeze_q) begin
                        freeze_d = 1'b0;
                    end else begin
                        freeze_d = 1'b1;
                        lap_d    = count_q;
                    end
                end
                // stop wins over a coincident tick, so count holds.
                if (stop) begin
                    state_d = S_STOP;
                end else if (tick) begin
                    if (!dir) begin
                        count_d = cnt_up;
                        wrap_d  = cnt_max;
                    end else begin
                        count_d = count_q - CNT_W'(1);
                        if (count_q == CNT_W'(1)) begin
                            alarm_d = 1'b1;
                            state_d = S_DONE;
                        end else if (count_q == '0) begin
                            // dir flipped to down while at 0 mid-run.
                            wrap_d = 1'b1;
                        end
                    end
                end
            end
            S_INC: begin
                if (stop || !inc) begin
                    state_d = S_STOP;
                end else if (tick) begin
                    if (hold_q == HC_LAST) begin
                        count_d = cnt_up;
                        wrap_d  = cnt_max;
                    end else begin
                        hold_d = hold_q + HC_W'(1);
                    end
                end
            end
            S_DONE: begin
                count_d = '0;
                if (stop) begin
                    state_d = S_STOP;
                end else if (load) begin
                    count_d  = load_val;
                    freeze_d = 1'b0;
                    state_d  = S_STOP;
                end
            end
            default: state_d = S_STOP;
        endcase

        if (!counting || tick || state_d != state_q) begin
            presc_d = '0;
        end else begin
            presc_d = presc_q + PS_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_STOP;
            count_q  <= '0;
            lap_q    <= '0;
            presc_q  <= '0;
            hold_q   <= '0;
            freeze_q <= 1'b0;
            alarm_q  <= 1'b0;
            wrap_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            lap_q    <= lap_d;
            presc_q  <= presc_d;
            hold_q   <= hold_d;
            freeze_q <= freeze_d;
            alarm_q  <= alarm_d;
            wrap_q   <= wrap_d;
        end
    end

    assign state   = state_q;
    assign count   = count_q;
    assign display = freeze_q ? lap_q : count_q;
    assign alarm   = alarm_q;
    assign wrap    = wrap_q;

endmodule

// File: tb/tb_timer_ctrl.sv
// tb_timer_ctrl: directed vector table plus hand sequences for timer_ctrl
// with CNT_W=4, PRESCALE=4, HOLD_TICKS=2.
module tb_timer_ctrl;

    localparam logic [5:0] ST = 6'b100000;
    localparam logic [5:0] SP = 6'b010000;
    localparam logic [5:0] IN = 6'b001000;
    localparam logic [5:0] LP = 6'b000100;
    localparam logic [5:0] DR = 6'b000010;
    localparam logic [5:0] LD = 6'b000001;

    localparam logic [1:0] S_STOP = 2'b00;
    localparam logic [1:0] S_RUN  = 2'b01;
    localparam logic [1:0] S_INC  = 2'b10;
    localparam logic [1:0] S_DONE = 2'b11;

    typedef struct {
        logic [5:0] in_bits;
        logic [3:0] lv;
        logic [1:0] e_state;
        logic [3:0] e_cnt;
        logic [3:0] e_disp;
        logic       e_alarm;
        logic       e_wrap;
    } vec_t;

    logic       clk;
    logic       reset_n;
    logic       start, stop, inc, lap, dir, load;
    logic [3:0] load_val;
    logic [1:0] state;
    logic [3:0] count;
    logic [3:0] display;
    logic       alarm;
    logic       wrap;

    int n_vec;
    int n_err;
    vec_t vecs[$];

    timer_ctrl #(
        .CNT_W(4),
        .PRESCALE(4),
        .HOLD_TICKS(2)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .start(start),
        .stop(stop),
        .inc(inc),
        .lap(lap),
        .dir(dir),
        .load(load),
        .load_val(load_val),
        .state(state),
        .count(count),
        .display(display),
        .alarm(alarm),
        .wrap(wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void add(input logic [5:0] ib, input logic [3:0] lv,
                                input logic [1:0] s, input logic [3:0] c,
                                input logic [3:0] d, input logic a,
                                input logic w);
        vec_t v;
        v.in_bits = ib;
        v.lv      = lv;
        v.e_state = s;
        v.e_cnt   = c;
        v.e_disp  = d;
        v.e_alarm = a;
        v.e_wrap  = w;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic [1:0] s,
                         input logic [3:0] c, input logic [3:0] d,
                         input logic a, input logic w);
        n_vec++;
        if ({state, count, display, alarm, wrap} !== {s, c, d, a, w}) begin
            n_err++;
            $display("FAIL %s: got st=%0d cnt=%0d disp=%0d al=%0b wr=%0b, want st=%0d cnt=%0d disp=%0d al=%0b wr=%0b",
                     name, state, count, display, alarm, wrap, s, c, d, a, w);
        end
    endtask

    task automatic apply(input logic [5:0] ib, input logic [3:0] lv);
        {start, stop, inc, lap, dir, load} = ib;
        load_val = lv;
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input vec_t v, input string name);
        apply(v.in_bits, v.lv);
        check(name, v.e_state, v.e_cnt, v.e_disp, v.e_alarm, v.e_wrap);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        reset_n = 1'b0;
        {start, stop, inc, lap, dir, load} = '0;
        load_val = '0;

        // STOP priorities and a first run tick
        add(0,     0, S_STOP, 0, 0, 0, 0);
        add(ST|SP, 0, S_STOP, 0, 0, 0, 0);
        add(ST|DR, 0, S_STOP, 0, 0, 0, 0);
        add(ST|IN, 0, S_RUN,  0, 0, 0, 0);
        for (int i = 0; i < 3; i++) add(0, 0, S_RUN, 0, 0, 0, 0);
        add(0,     0, S_RUN,  1, 1, 0, 0);
        add(SP,    0, S_STOP, 1, 1, 0, 0);
        // countdown 3 -> 0 with alarm
        add(LD,    3, S_STOP, 3, 3, 0, 0);
        add(ST|DR, 0, S_RUN,  3, 3, 0, 0);
        for (int i = 0; i < 3; i++) add(DR, 0, S_RUN, 3, 3, 0, 0);
        add(DR,    0, S_RUN,  2, 2, 0, 0);
        for (int i = 0; i < 3; i++) add(DR, 0, S_RUN, 2, 2, 0, 0);
        add(DR,    0, S_RUN,  1, 1, 0, 0);
        for (int i = 0; i < 3; i++) add(DR, 0, S_RUN, 1, 1, 0, 0);
        add(DR,    0, S_DONE, 0, 0, 1, 0);
        add(ST|DR, 0, S_DONE, 0, 0, 0, 0);
        add(IN,    0, S_DONE, 0, 0, 0, 0);
        add(SP,    0, S_STOP, 0, 0, 0, 0);
        // count-up wrap, then stop coinciding with a tick
        add(LD,   14, S_STOP, 14, 14, 0, 0);
        add(ST,    0, S_RUN,  14, 14, 0, 0);
        for (int i = 0; i < 3; i++) add(0, 0, S_RUN, 14, 14, 0, 0);
        add(0,     0, S_RUN,  15, 15, 0, 0);
        for (int i = 0; i < 3; i++) add(0, 0, S_RUN, 15, 15, 0, 0);
        add(0,     0, S_RUN,  0, 0, 0, 1);
        for (int i = 0; i < 3; i++) add(0, 0, S_RUN, 0, 0, 0, 0);
        add(SP,    0, S_STOP, 0, 0, 0, 0);
        // lap freeze / unfreeze
        add(LD,    5, S_STOP, 5, 5, 0, 0);
        add(ST,    0, S_RUN,  5, 5, 0, 0);
        for (int i = 0; i < 3; i++) add(0, 0, S_RUN, 5, 5, 0, 0);
        add(0,     0, S_RUN,  6, 6, 0, 0);
        add(LP,    0, S_RUN,  6, 6, 0, 0);
        for (int i = 0; i < 2; i++) add(0, 0, S_RUN, 6, 6, 0, 0);
        add(0,     0, S_RUN,  7, 6, 0, 0);
        for (int i = 0; i < 3; i++) add(0, 0, S_RUN, 7, 6, 0, 0);
        add(0,     0, S_RUN,  8, 6, 0, 0);
        for (int i = 0; i < 3; i++) add(0, 0, S_RUN, 8, 6, 0, 0);
        add(0,     0, S_RUN,  9, 6, 0, 0);
        add(LP,    0, S_RUN,  9, 9, 0, 0);
        for (int i = 0; i < 2; i++) add(0, 0, S_RUN, 9, 9, 0, 0);
        add(0,     0, S_RUN,  10, 10, 0, 0);
        add(LP,    0, S_RUN,  10, 10, 0, 0);
        add(SP,    0, S_STOP, 10, 10, 0, 0);
        add(LP,    0, S_STOP, 10, 10, 0, 0);
        add(IN,    0, S_INC,  11, 10, 0, 0);
        add(0,     0, S_STOP, 11, 10, 0, 0);
        add(LD,    0, S_STOP, 0, 0, 0, 0);
        add(LP,    0, S_STOP, 0, 0, 0, 0);
        add(IN,    0, S_INC,  1, 1, 0, 0);
        add(0,     0, S_STOP, 1, 1, 0, 0);

        #3;
        check("reset_state", S_STOP, 0, 0, 0, 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < vecs.size(); i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // inc held 20 cycles: auto-repeat from the 2nd tick, then every tick
        apply(LD, 0);
        check("inc_preload", S_STOP, 0, 0, 0, 0);
        apply(IN, 0);
        check("inc_entry", S_INC, 1, 1, 0, 0);
        for (int k = 1; k <= 20; k++) begin
            logic [3:0] e;
            e = 4'd1 + 4'(k >= 8) + 4'(k >= 12) + 4'(k >= 16) + 4'(k >= 20);
            apply(IN, 0);
            check($sformatf("inc_hold%0d", k), S_INC, e, e, 0, 0);
        end
        apply(0, 0);
        check("inc_release", S_STOP, 5, 5, 0, 0);

        // asynchronous reset while running at count 5
        apply(LD, 5);
        apply(ST, 0);
        apply(0, 0);
        check("pre_reset_run", S_RUN, 5, 5, 0, 0);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_reset", S_STOP, 0, 0, 0, 0);
        @(negedge clk);
        reset_n = 1'b1;
        apply(0, 0);
        check("post_reset", S_STOP, 0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
